// File: rtl/dffram_rr_ctrl.sv
// dffram_rr_ctrl
// Two-requester round-robin arbiter and sequencer for one single-port
// DFFRAM256x32-style macro. At most one command per cycle is accepted from
// either requester. The macro pins are driven from registers. Read data is
// returned to the originating requester with a fixed latency.
//
// Ports
//   CLK, RST              clock (posedge) and asynchronous active-high reset
//   Rx_REQ                requester x command valid
//   Rx_WE                 requester x byte write mask (all zero = read)
//   Rx_A                  requester x word address
//   Rx_DI                 requester x write data
//   Rx_ACK                command accepted this cycle (combinational)
//   Rx_RVALID             read data for requester x valid on RDATA
//   RDATA                 shared read-data return, straight from Do0
//   EN0, WE0, A0, Di0     registered macro controls
//   Do0                   macro read data
module dffram_rr_ctrl #(
  parameter int AW     = 8,
  parameter int WSIZE  = 4,
  parameter int RD_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 R0_REQ,
  input  logic [WSIZE-1:0]     R0_WE,
  input  logic [AW-1:0]        R0_A,
  input  logic [WSIZE*8-1:0]   R0_DI,
  output logic                 R0_ACK,
  output logic                 R0_RVALID,
  input  logic                 R1_REQ,
  input  logic [WSIZE-1:0]     R1_WE,
  input  logic [AW-1:0]        R1_A,
  input  logic [WSIZE*8-1:0]   R1_DI,
  output logic                 R1_ACK,
  output logic                 R1_RVALID,
  output logic [WSIZE*8-1:0]   RDATA,
  output logic                 EN0,
  output logic [WSIZE-1:0]     WE0,
  output logic [AW-1:0]        A0,
  output logic [WSIZE*8-1:0]   Di0,
  input  logic [WSIZE*8-1:0]   Do0
);

  localparam int DW = WSIZE * 8;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_gnt_any;
  logic             w_gnt_rd;
  logic [WSIZE-1:0] w_gnt_we;
  logic [AW-1:0]    w_gnt_a;
  logic [DW-1:0]    w_gnt_di;

  // r_ptr: 0 favours requester 0 under contention, 1 favours requester 1
  logic             r_ptr;

  // Read tag pipeline: index 0 is loaded at the accepting edge, index
  // RD_LAT lines up with the cycle in which the macro presents Do0.
  logic [RD_LAT:0]  r_tag_v;
  logic [RD_LAT:0]  r_tag_id;

  // Arbitration: a lone requester wins; on contention the pointer decides.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (R0_REQ && R1_REQ) begin
      w_gnt0 = ~r_ptr;
      w_gnt1 = r_ptr;
    end else if (R0_REQ) begin
      w_gnt0 = 1'b1;
    end else if (R1_REQ) begin
      w_gnt1 = 1'b1;
    end else begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign w_gnt_any = w_gnt0 | w_gnt1;

  // ACK must never be seen during reset, since nothing would be captured.
  assign R0_ACK = w_gnt0 & ~RST;
  assign R1_ACK = w_gnt1 & ~RST;

  // Command mux: pick the granted requester's fields.
  always_comb begin
    w_gnt_we = R0_WE;
    w_gnt_a  = R0_A;
    w_gnt_di = R0_DI;
    if (w_gnt1) begin
      w_gnt_we = R1_WE;
      w_gnt_a  = R1_A;
      w_gnt_di = R1_DI;
    end else begin
      w_gnt_we = R0_WE;
      w_gnt_a  = R0_A;
      w_gnt_di = R0_DI;
    end
  end

  assign w_gnt_rd = (w_gnt_we == {WSIZE{1'b0}});

  // Macro command registers; A0/Di0 hold when idle to avoid needless toggling.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      EN0 <= 1'b0;
      WE0 <= {WSIZE{1'b0}};
      A0  <= {AW{1'b0}};
      Di0 <= {DW{1'b0}};
    end else if (w_gnt_any) begin
      EN0 <= 1'b1;
      WE0 <= w_gnt_we;
      A0  <= w_gnt_a;
      Di0 <= w_gnt_di;
    end else begin
      EN0 <= 1'b0;
      WE0 <= {WSIZE{1'b0}};
    end
  end

  // Round-robin pointer: after a grant, favour the requester not just served.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ptr <= 1'b0;
    end else if (w_gnt_any) begin
      r_ptr <= w_gnt0;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Read tag shift register; advances every cycle so reads never stall.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tag_v  <= {(RD_LAT + 1){1'b0}};
      r_tag_id <= {(RD_LAT + 1){1'b0}};
    end else begin
      r_tag_v[0]  <= w_gnt_any & w_gnt_rd;
      r_tag_id[0] <= w_gnt1;
      for (int i = 1; i <= RD_LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  // Return path: the last tag stage is a register, so RVALID is glitch-free.
  assign R0_RVALID = r_tag_v[RD_LAT] & ~r_tag_id[RD_LAT];
  assign R1_RVALID = r_tag_v[RD_LAT] &  r_tag_id[RD_LAT];
  assign RDATA     = Do0;

endmodule

// File: tb/tb_dffram_rr_ctrl.sv
module tb_dffram_rr_ctrl;

  logic        clk;
  logic        rst;
  logic        r0_req, r1_req;
  logic [3:0]  r0_we, r1_we;
  logic [7:0]  r0_a, r1_a;
  logic [31:0] r0_di, r1_di;
  logic        r0_ack, r1_ack, r0_rvalid, r1_rvalid;
  logic [31:0] rdata;
  logic        en0;
  logic [3:0]  we0;
  logic [7:0]  a0;
  logic [31:0] di0;
  logic [31:0] do0;

  dffram_rr_ctrl #(.AW(8), .WSIZE(4), .RD_LAT(1)) dut (
    .CLK(clk), .RST(rst),
    .R0_REQ(r0_req), .R0_WE(r0_we), .R0_A(r0_a), .R0_DI(r0_di),
    .R0_ACK(r0_ack), .R0_RVALID(r0_rvalid),
    .R1_REQ(r1_req), .R1_WE(r1_we), .R1_A(r1_a), .R1_DI(r1_di),
    .R1_ACK(r1_ack), .R1_RVALID(r1_rvalid),
    .RDATA(rdata), .EN0(en0), .WE0(we0), .A0(a0), .Di0(di0), .Do0(do0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural macro: samples on posedge, Do0 valid one cycle later.
  logic [31:0] mem [0:255];
  logic [31:0] ram_nw;
  always @(posedge clk) begin
    if (en0) begin
      if (we0 == 4'b0000) begin
        do0 <= mem[a0];
      end else begin
        ram_nw = mem[a0];
        for (int b = 0; b < 4; b++)
          if (we0[b]) ram_nw[b*8 +: 8] = di0[b*8 +: 8];
        mem[a0] <= ram_nw;
      end
    end
  end

  typedef struct { int id; logic [31:0] data; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expected response whenever the DUT presents read data.
  always @(negedge clk) begin
    if (r0_rvalid || r1_rvalid) begin
      check("rvalid_onehot", 32'(r0_rvalid & r1_rvalid), 32'd0);
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rvalid: r0=%b r1=%b rdata=%h, none outstanding at %0t",
                 r0_rvalid, r1_rvalid, rdata, $time);
      end else begin
        mon_e = sbq.pop_front();
        check("rvalid_id", 32'(r1_rvalid), 32'(mon_e.id));
        check("rdata", rdata, mon_e.data);
      end
    end
  end

  // Issue one command from one requester; expects an immediate ACK.
  task automatic cmd(input int id, input logic [3:0] we, input logic [7:0] a,
                     input logic [31:0] di, input logic [31:0] exp_rd);
    int  waits;
    logic got;
    waits = 0;
    got   = 1'b0;
    if (id == 0) begin r0_req = 1'b1; r0_we = we; r0_a = a; r0_di = di; end
    else         begin r1_req = 1'b1; r1_we = we; r1_a = a; r1_di = di; end
    while (!got && waits < 20) begin
      @(negedge clk);
      if ((id == 0) ? r0_ack : r1_ack) begin
        got = 1'b1;
        if (we == 4'b0000) sbq.push_back('{id, exp_rd});
      end else begin
        waits++;
      end
      @(posedge clk); #1;
    end
    check("ack_latency", 32'(waits), 32'd0);
    if (id == 0) r0_req = 1'b0; else r1_req = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    do0 = 32'h0000_0000;
    rst = 1'b1;
    r0_req = 1'b0; r0_we = 4'h0; r0_a = 8'h00; r0_di = 32'h0;
    r1_req = 1'b0; r1_we = 4'h0; r1_a = 8'h00; r1_di = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_en0", 32'(en0), 32'd0);
    check("rst_we0", 32'(we0), 32'd0);
    check("rst_rvalid", 32'({r0_rvalid, r1_rvalid}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single requester back-to-back writes then reads
    cmd(0, 4'hF, 8'h00, 32'hAA0055BB, 32'h0);
    cmd(0, 4'hF, 8'h01, 32'hAA0055CC, 32'h0);
    cmd(0, 4'hF, 8'h02, 32'hAA0055DD, 32'h0);
    cmd(0, 4'h0, 8'h00, 32'h0, 32'hAA0055BB);
    cmd(0, 4'h0, 8'h01, 32'h0, 32'hAA0055CC);
    cmd(0, 4'h0, 8'h02, 32'h0, 32'hAA0055DD);

    // Byte masks from requester 1
    cmd(1, 4'hF, 8'hF2, 32'hF0F055DD, 32'h0);
    cmd(1, 4'hF, 8'hF1, 32'hF0F055CC, 32'h0);
    cmd(1, 4'hF, 8'hF0, 32'hF0F055BB, 32'h0);
    cmd(1, 4'b0001, 8'hF2, 32'hAB000033, 32'h0);
    cmd(1, 4'b0010, 8'hF1, 32'hAB003300, 32'h0);
    cmd(1, 4'b0100, 8'hF0, 32'hAB330000, 32'h0);
    cmd(1, 4'h0, 8'hF2, 32'h0, 32'hF0F05533);
    cmd(1, 4'h0, 8'hF1, 32'h0, 32'hF0F033CC);
    cmd(1, 4'h0, 8'hF0, 32'h0, 32'hF03355BB);

    // Contention: preload, last grant to R1 leaves pointer on R0
    cmd(0, 4'hF, 8'h10, 32'h11110010, 32'h0);
    cmd(1, 4'hF, 8'h11, 32'h22220011, 32'h0);
    r0_req = 1'b1; r0_we = 4'h0; r0_a = 8'h10;
    r1_req = 1'b1; r1_we = 4'h0; r1_a = 8'h11;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("cont_ack0", 32'(r0_ack), 32'(i % 2 == 0));
      check("cont_ack1", 32'(r1_ack), 32'(i % 2 == 1));
      if (i % 2 == 0) sbq.push_back('{0, 32'h11110010});
      else            sbq.push_back('{1, 32'h22220011});
      @(posedge clk); #1;
    end
    r0_req = 1'b0; r1_req = 1'b0;

    // RAW hazard across requesters
    cmd(0, 4'hF, 8'h20, 32'h12345678, 32'h0);
    cmd(1, 4'h0, 8'h20, 32'h0, 32'h12345678);

    // Idle: macro disabled, address held
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("idle_en0", 32'(en0), 32'd0);
      check("idle_we0", 32'(we0), 32'd0);
      check("idle_a0_hold", 32'(a0), 32'h20);
    end
    @(posedge clk); #1;

    // Address wrap
    cmd(0, 4'hF, 8'hFF, 32'hDEADBEEF, 32'h0);
    cmd(0, 4'h0, 8'hFF, 32'h0, 32'hDEADBEEF);
    cmd(0, 4'h0, 8'h00, 32'h0, 32'hAA0055BB);
    wait_drain();

    // Reset with a read in flight; pointer left on R1 beforehand
    r0_req = 1'b1; r0_we = 4'h0; r0_a = 8'h03;
    @(negedge clk);
    check("pre_rst_ack", 32'(r0_ack), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    r0_a = 8'h00;
    r1_req = 1'b1; r1_we = 4'h0; r1_a = 8'h01;
    @(negedge clk);
    check("mid_rst_en0", 32'(en0), 32'd0);
    check("mid_rst_we0", 32'(we0), 32'd0);
    check("mid_rst_a0", 32'(a0), 32'd0);
    check("mid_rst_di0", 32'(di0), 32'd0);
    check("mid_rst_acks", 32'({r0_ack, r1_ack}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_rvalid", 32'({r0_rvalid, r1_rvalid}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ack0", 32'(r0_ack), 32'd1);
    check("post_rst_ack1", 32'(r1_ack), 32'd0);
    sbq.push_back('{0, 32'hAA0055BB});
    @(posedge clk); #1;
    r0_req = 1'b0;
    @(negedge clk);
    check("post_rst_r1_ack", 32'(r1_ack), 32'd1);
    sbq.push_back('{1, 32'hAA0055CC});
    @(posedge clk); #1;
    r1_req = 1'b0;
    wait_drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
